// File: rtl/alu_exec_stage.sv
// Execute stage: registers {opcode,a,b}, runs the 8-bit alu, queues {result,flags} in an in-order FIFO.
// Latency: op accepted at edge t is visible at the FIFO head after edge t+1 (FIFO empty or popping).
// Backpressure: S1 holds its op while the FIFO is full and not popping; in_ready drops when S1 is then occupied.
// Optional feature: define ALU_STICKY_FLAGS_EN to add sticky_clr / sticky_flags.

// Combinational 8-bit ALU; flags are {O,N,C,Z}, C is carry for ADD/INC and borrow for SUB/DEC.
module alu (
  input  logic [2:0] opcode,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] result,
  output logic [3:0] flags
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_NOT = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_INC = 3'd6;
  localparam logic [2:0] OP_DEC = 3'd7;

  logic [8:0] wide;
  logic       c_flag;
  logic       o_flag;

  // Per-opcode result, carry/borrow and signed overflow.
  always_comb begin
    wide   = 9'd0;
    c_flag = 1'b0;
    o_flag = 1'b0;
    case (opcode)
      OP_ADD: begin
        wide   = {1'b0, a} + {1'b0, b};
        c_flag = wide[8];
        o_flag = (a[7] == b[7]) && (wide[7] != a[7]);
      end
      OP_SUB: begin
        wide   = {1'b0, a} - {1'b0, b};
        c_flag = wide[8];
        o_flag = (a[7] != b[7]) && (wide[7] != a[7]);
      end
      OP_AND: wide = {1'b0, a & b};
      OP_OR:  wide = {1'b0, a | b};
      OP_NOT: wide = {1'b0, ~a};
      OP_XOR: wide = {1'b0, a ^ b};
      OP_INC: begin
        wide   = {1'b0, a} + 9'd1;
        c_flag = wide[8];
        o_flag = (a == 8'h7f);
      end
      OP_DEC: begin
        wide   = {1'b0, a} - 9'd1;
        c_flag = wide[8];
        o_flag = (a == 8'h80);
      end
      default: wide = 9'd0;
    endcase
  end

  assign result = wide[7:0];
  assign flags  = {o_flag, wide[7], c_flag, (wide[7:0] == 8'd0)};

endmodule

module alu_exec_stage #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [2:0]                    in_opcode,
  input  logic [7:0]                    in_a,
  input  logic [7:0]                    in_b,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [7:0]                    out_result,
  output logic [3:0]                    out_flags,
  output logic [$clog2(FIFO_DEPTH):0]   level,
`ifdef ALU_STICKY_FLAGS_EN
  input  logic                          sticky_clr,
  output logic [3:0]                    sticky_flags,
`endif
  output logic [CNT_W-1:0]              op_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(FIFO_DEPTH);

  // S1 operand register
  logic       s1_valid;
  logic [2:0] s1_opcode;
  logic [7:0] s1_a;
  logic [7:0] s1_b;

  // FIFO storage: each entry is {result[7:0], flags[3:0]}
  logic [11:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] cnt;

  logic [7:0] alu_result;
  logic [3:0] alu_flags;
  logic       pop;
  logic       push_ok;
  logic       push;
  logic       accept;

  alu u_alu (
    .opcode (s1_opcode),
    .a      (s1_a),
    .b      (s1_b),
    .result (alu_result),
    .flags  (alu_flags)
  );

  // A full FIFO still accepts a push when its head leaves on the same edge.
  assign out_valid = (cnt != '0);
  assign pop       = out_valid & out_ready;
  assign push_ok   = (cnt < DEPTH_L) | pop;
  assign push      = s1_valid & push_ok;
  assign in_ready  = !rst & (!s1_valid | push_ok);
  assign accept    = in_valid & in_ready;

  assign out_result = mem[rd_ptr][11:4];
  assign out_flags  = mem[rd_ptr][3:0];
  assign level      = cnt;

  // S1: load on accept, otherwise empty out once its op has been pushed.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_opcode <= 3'd0;
      s1_a      <= 8'd0;
      s1_b      <= 8'd0;
    end else if (accept) begin
      s1_valid  <= 1'b1;
      s1_opcode <= in_opcode;
      s1_a      <= in_a;
      s1_b      <= in_b;
    end else if (push) begin
      s1_valid  <= 1'b0;
    end
  end

  // FIFO storage and pointers; storage is cleared so the empty head reads zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 12'd0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {alu_result, alu_flags};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Occupancy counter kept separately from the pointers so full and empty never alias.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Completed-op counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (rst)       op_count <= '0;
    else if (push) op_count <= op_count + 1'b1;
  end

`ifdef ALU_STICKY_FLAGS_EN
  // Sticky flags accumulate every push; a clear coinciding with a push keeps only that push's flags.
  always_ff @(posedge clk) begin
    if (rst)             sticky_flags <= 4'd0;
    else if (sticky_clr) sticky_flags <= push ? alu_flags : 4'd0;
    else if (push)       sticky_flags <= sticky_flags | alu_flags;
  end
`endif

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed self-checking bench for alu_exec_stage (FIFO_DEPTH=4, CNT_W=16).
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_opcode = 3'd0;
  logic [7:0]  in_a = 8'd0;
  logic [7:0]  in_b = 8'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_result;
  logic [3:0]  out_flags;
  logic [2:0]  level;
  logic [15:0] op_count;
`ifdef ALU_STICKY_FLAGS_EN
  logic        sticky_clr = 1'b0;
  logic [3:0]  sticky_flags;
`endif

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;

  alu_exec_stage #(.FIFO_DEPTH(4), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags),
    .level      (level),
`ifdef ALU_STICKY_FLAGS_EN
    .sticky_clr   (sticky_clr),
    .sticky_flags (sticky_flags),
`endif
    .op_count   (op_count)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle; all driving and sampling happen 1 time unit after posedge.
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    step; step;
    rst = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step; step;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready_during got=%b want=0", in_ready); end
    rst = 1'b0;
    exp_cnt = 0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready_after got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (level !== 3'd0) begin bad++; $display("FAIL reset_level got=%0d want=0", level); end
    total++; if (op_count !== 16'd0) begin bad++; $display("FAIL reset_op_count got=%0d want=0", op_count); end
    total++; if (out_result !== 8'd0 || out_flags !== 4'd0) begin bad++; $display("FAIL reset_out_data got=%0d/%b want=0/0000", out_result, out_flags); end
  endtask

  task automatic test_add;
    out_ready = 1'b1;
    in_valid = 1'b1; in_opcode = 3'd0; in_a = 8'd5; in_b = 8'd4;
    step;
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL add_early_valid got=%b want=0", out_valid); end
    step;
    exp_cnt++;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL add_valid got=%b want=1", out_valid); end
    total++; if (out_result !== 8'd9) begin bad++; $display("FAIL add_result got=%0d want=9", out_result); end
    total++; if (out_flags !== 4'b0000) begin bad++; $display("FAIL add_flags got=%b want=0000", out_flags); end
    total++; if (op_count !== 16'(exp_cnt)) begin bad++; $display("FAIL add_op_count got=%0d want=%0d", op_count, exp_cnt); end
    step;
    total++; if (level !== 3'd0) begin bad++; $display("FAIL add_pop_level got=%0d want=0", level); end
  endtask

  task automatic test_corner_ops;
    logic [2:0] t_op  [12] = '{3'd6, 3'd7, 3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd6, 3'd7};
    logic [7:0] t_a   [12] = '{8'd255, 8'd0, 8'd70, 8'd3, 8'h80, 8'hF0, 8'hF0, 8'h0F, 8'hAA, 8'd200, 8'd127, 8'd128};
    logic [7:0] t_b   [12] = '{8'd0, 8'd0, 8'd80, 8'd5, 8'd1, 8'h0F, 8'h0F, 8'd0, 8'hFF, 8'd100, 8'd0, 8'd0};
    logic [7:0] t_res [12] = '{8'd0, 8'd255, 8'd150, 8'd254, 8'h7F, 8'h00, 8'hFF, 8'hF0, 8'h55, 8'd44, 8'd128, 8'd127};
    logic [3:0] t_flg [12] = '{4'b0011, 4'b0110, 4'b1100, 4'b0110, 4'b1000, 4'b0001, 4'b0100, 4'b0100, 4'b0000, 4'b0010, 4'b1100, 4'b1000};
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; in_opcode = t_op[i]; in_a = t_a[i]; in_b = t_b[i];
      step;
      in_valid = 1'b0;
      step;
      exp_cnt++;
      total++; if (out_valid !== 1'b1 || out_result !== t_res[i]) begin bad++; $display("FAIL corner_result[%0d] got=%b/%0d want=1/%0d", i, out_valid, out_result, t_res[i]); end
      total++; if (out_flags !== t_flg[i]) begin bad++; $display("FAIL corner_flags[%0d] got=%b want=%b", i, out_flags, t_flg[i]); end
      step;
    end
    total++; if (op_count !== 16'(exp_cnt)) begin bad++; $display("FAIL corner_op_count got=%0d want=%0d", op_count, exp_cnt); end
  endtask

  task automatic test_backpressure;
    int accepted = 0;
    apply_reset;
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (accepted < 6) begin
        in_valid = 1'b1; in_opcode = 3'd0; in_a = 8'(10 + accepted); in_b = 8'd1;
      end else in_valid = 1'b0;
      #1;
      if (in_valid && in_ready) accepted++;
      step;
    end
    total++; if (accepted !== 5) begin bad++; $display("FAIL bp_accepted got=%0d want=5", accepted); end
    total++; if (level !== 3'd4) begin bad++; $display("FAIL bp_level got=%0d want=4", level); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b want=0", in_ready); end
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      total++; if (out_valid !== 1'b1 || out_result !== 8'(11 + k)) begin bad++; $display("FAIL bp_drain[%0d] got=%b/%0d want=1/%0d", k, out_valid, out_result, 11 + k); end
      total++; if (level !== ((k == 0) ? 3'd4 : 3'(5 - k))) begin bad++; $display("FAIL bp_drain_level[%0d] got=%0d want=%0d", k, level, (k == 0) ? 4 : 5 - k); end
      step;
    end
    total++; if (out_valid !== 1'b0 || level !== 3'd0) begin bad++; $display("FAIL bp_empty got=%b/%0d want=0/0", out_valid, level); end
    total++; if (op_count !== 16'd5) begin bad++; $display("FAIL bp_op_count got=%0d want=5", op_count); end
  endtask

  task automatic test_streaming;
    int rx = 0;
    int max_lvl = 0;
    int not_ready = 0;
    int order_err = 0;
    apply_reset;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 26; cyc++) begin
      if (cyc < 20) begin
        in_valid = 1'b1; in_opcode = 3'd0; in_a = 8'(cyc); in_b = 8'd100;
      end else in_valid = 1'b0;
      #1;
      if (cyc < 20 && in_ready !== 1'b1) not_ready++;
      if (out_valid === 1'b1) begin
        if (out_result !== 8'(rx + 100)) begin
          order_err++;
          $display("FAIL stream_result[%0d] got=%0d want=%0d", rx, out_result, rx + 100);
        end
        rx++;
      end
      if (int'(level) > max_lvl) max_lvl = int'(level);
      step;
    end
    in_valid = 1'b0;
    total++; if (not_ready !== 0) begin bad++; $display("FAIL stream_in_ready got=%0d stalls want=0", not_ready); end
    total++; if (order_err !== 0) begin bad++; $display("FAIL stream_order got=%0d errors want=0", order_err); end
    total++; if (rx !== 20) begin bad++; $display("FAIL stream_count got=%0d want=20", rx); end
    total++; if (max_lvl > 1) begin bad++; $display("FAIL stream_level got=%0d want<=1", max_lvl); end
    total++; if (op_count !== 16'd20) begin bad++; $display("FAIL stream_op_count got=%0d want=20", op_count); end
  endtask

  task automatic test_reset_mid;
    int stale = 0;
    apply_reset;
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      in_valid = 1'b1; in_opcode = 3'd6; in_a = 8'(cyc + 40); in_b = 8'd0;
      step;
    end
    in_valid = 1'b0;
    total++; if (level !== 3'd3) begin bad++; $display("FAIL mid_pre_level got=%0d want=3", level); end
    rst = 1'b1;
    step;
    rst = 1'b0;
    exp_cnt = 0;
    #1;
    total++; if (out_valid !== 1'b0 || level !== 3'd0) begin bad++; $display("FAIL mid_cleared got=%b/%0d want=0/0", out_valid, level); end
    total++; if (op_count !== 16'd0) begin bad++; $display("FAIL mid_op_count got=%0d want=0", op_count); end
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      step;
      if (out_valid !== 1'b0 || level !== 3'd0) stale++;
    end
    total++; if (stale !== 0) begin bad++; $display("FAIL mid_stale got=%0d cycles want=0", stale); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_in_ready got=%b want=1", in_ready); end
  endtask

`ifdef ALU_STICKY_FLAGS_EN
  task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    in_valid = 1'b1; in_opcode = op; in_a = a; in_b = b;
    step;
    in_valid = 1'b0;
    step;
    step;
  endtask

  task automatic test_sticky;
    apply_reset;
    sticky_clr = 1'b0;
    out_ready = 1'b1;
    #1;
    total++; if (sticky_flags !== 4'b0000) begin bad++; $display("FAIL sticky_reset got=%b want=0000", sticky_flags); end
    run_op(3'd0, 8'd70, 8'd80);
    run_op(3'd2, 8'hF0, 8'h0F);
    total++; if (sticky_flags !== 4'b1101) begin bad++; $display("FAIL sticky_accum got=%b want=1101", sticky_flags); end
    sticky_clr = 1'b1;
    step;
    sticky_clr = 1'b0;
    total++; if (sticky_flags !== 4'b0000) begin bad++; $display("FAIL sticky_clear got=%b want=0000", sticky_flags); end
    run_op(3'd0, 8'd70, 8'd80);
    total++; if (sticky_flags !== 4'b1100) begin bad++; $display("FAIL sticky_reload got=%b want=1100", sticky_flags); end
    in_valid = 1'b1; in_opcode = 3'd2; in_a = 8'hF0; in_b = 8'h0F;
    step;
    in_valid = 1'b0;
    sticky_clr = 1'b1;
    step;
    sticky_clr = 1'b0;
    total++; if (sticky_flags !== 4'b0001) begin bad++; $display("FAIL sticky_clr_push got=%b want=0001", sticky_flags); end
  endtask
`endif

  initial begin
    test_reset;
    test_add;
    test_corner_ops;
    test_backpressure;
    test_streaming;
    test_reset_mid;
`ifdef ALU_STICKY_FLAGS_EN
    test_sticky;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
